// File: rtl/ghash_mul_scheduler.sv
// GHASH chain sequencer: Y_i = (Y_{i-1} ^ X_i) * H over GF(2^128), one multiply in flight.
// Folds each 255-bit product from the external multiplier back into the field.
module ghash_mul_scheduler #(
  parameter int WIDTH = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   h_i,
  input  logic               blk_valid_i,
  input  logic [WIDTH-1:0]   blk_data_i,
  input  logic               blk_last_i,
  output logic               blk_ready_o,
  output logic               mul_valid_o,
  output logic [WIDTH-1:0]   mul_a_o,
  output logic [WIDTH-1:0]   mul_b_o,
  input  logic               mul_valid_i,
  input  logic [2*WIDTH-1:0] mul_result_i,
  output logic               tag_valid_o,
  output logic [WIDTH-1:0]   tag_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] tag_q, tag_d;
  logic             last_q, last_d;

  // Reduction mod x^128 + x^7 + x^2 + x + 1: fold the high half, then the <=7 overflow bits.
  logic [WIDTH-2:0] p_hi;
  logic [WIDTH+6:0] p_hi_ext;
  logic [WIDTH+6:0] fold1;
  logic [6:0]       ovf;
  logic [WIDTH-1:0] ovf_ext;
  logic [WIDTH-1:0] fold2;
  logic [WIDTH-1:0] red;
  logic             unused_msb;

  assign unused_msb = mul_result_i[2*WIDTH-1];

  always_comb begin
    p_hi     = mul_result_i[2*WIDTH-2:WIDTH];
    p_hi_ext = {8'b0, p_hi};
    fold1    = p_hi_ext ^ (p_hi_ext << 1) ^ (p_hi_ext << 2) ^ (p_hi_ext << 7);
    ovf      = fold1[WIDTH+6:WIDTH];
    ovf_ext  = {{(WIDTH-7){1'b0}}, ovf};
    fold2    = ovf_ext ^ (ovf_ext << 1) ^ (ovf_ext << 2) ^ (ovf_ext << 7);
    red      = mul_result_i[WIDTH-1:0] ^ fold1[WIDTH-1:0] ^ fold2;
  end

  // Handshake: a block transfers on any cycle where blk_valid_i && blk_ready_o;
  // blk_ready_o depends only on state, never on blk_valid_i.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    y_d     = y_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          h_d     = h_i;
          y_d     = '0;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        if (blk_valid_i) begin
          a_d     = y_q ^ blk_data_i;
          b_d     = h_q;
          last_d  = blk_last_i;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mul_valid_i) begin
          y_d = red;
          if (last_q) begin
            tag_d   = red;
            state_d = DONE;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      y_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      y_q     <= y_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
    end
  end

  assign blk_ready_o = (state_q == ACCEPT);
  assign mul_valid_o = (state_q == ISSUE);
  assign tag_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign mul_a_o     = a_q;
  assign mul_b_o     = b_q;
  assign tag_o       = tag_q;

endmodule

// File: tb/tb_ghash_mul_scheduler.sv
// Randomised bench for ghash_mul_scheduler with a fixed-latency multiplier model
// and a long-division GF(2^128) reference.
module tb_ghash_mul_scheduler;
  localparam int W = 128;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic [W-1:0]   h_i = '0;
  logic           blk_valid_i = 1'b0;
  logic [W-1:0]   blk_data_i = '0;
  logic           blk_last_i = 1'b0;
  logic           blk_ready_o;
  logic           mul_valid_o;
  logic [W-1:0]   mul_a_o;
  logic [W-1:0]   mul_b_o;
  logic           mul_valid_i;
  logic [2*W-1:0] mul_result_i;
  logic           tag_valid_o;
  logic [W-1:0]   tag_o;
  logic           busy_o;

  always #5 clk = ~clk;

  ghash_mul_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .h_i(h_i),
    .blk_valid_i(blk_valid_i), .blk_data_i(blk_data_i), .blk_last_i(blk_last_i),
    .blk_ready_o(blk_ready_o), .mul_valid_o(mul_valid_o), .mul_a_o(mul_a_o),
    .mul_b_o(mul_b_o), .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i),
    .tag_valid_o(tag_valid_o), .tag_o(tag_o), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference arithmetic: carry-less product and polynomial long division.
  function automatic logic [2*W-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
    return p;
  endfunction

  function automatic logic [W-1:0] gf_reduce(input logic [2*W-1:0] p);
    logic [2*W-1:0] poly = '0;
    poly[W] = 1'b1;
    poly[7:0] = 8'h87;
    for (int i = 2*W-1; i >= W; i--)
      if (p[i]) p = p ^ (poly << (i - W));
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Multiplier model: result appears lat cycles after the issue cycle.
  int             lat = 4;
  int             mdl_cnt = 0;
  logic [2*W-1:0] mdl_pend = '0;
  logic           mdl_v = 1'b0;
  logic [2*W-1:0] mdl_r = '0;
  logic           inj_v = 1'b0;
  logic [2*W-1:0] inj_r = '0;

  assign mul_valid_i  = mdl_v | inj_v;
  assign mul_result_i = mdl_v ? mdl_r : inj_r;

  always @(negedge clk) begin
    mdl_v = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt = mdl_cnt - 1;
      if (mdl_cnt == 0) begin
        mdl_v = 1'b1;
        mdl_r = mdl_pend;
      end
    end
    if (mul_valid_o) begin
      mdl_pend = clmul(mul_a_o, mul_b_o);
      mdl_cnt  = lat;
    end
  end

  // Message stimulus and expected values.
  logic [W-1:0] blk_arr [8];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_tag;
  logic [W-1:0] obs_a_q [$];
  logic [W-1:0] obs_b_q [$];
  logic [W-1:0] obs_tag;
  int           obs_err;

  task automatic ghash_ref(input logic [W-1:0] h, input int n);
    logic [W-1:0] y = '0;
    logic [W-1:0] a;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = y ^ blk_arr[i];
      exp_q.push_back(a);
      y = gf_reduce(clmul(a, h));
    end
    exp_tag = y;
  endtask

  task automatic drive_msg(input logic [W-1:0] h, input int n, input bit inj_start,
                           input bit inj_mul, input int stall);
    int k;
    obs_a_q.delete();
    obs_b_q.delete();
    obs_err = 0;
    obs_tag = '0;
    @(negedge clk);
    start_i = 1'b1;
    h_i     = h;
    @(negedge clk);
    start_i = 1'b0;
    h_i     = rand128();
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!blk_ready_o && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (!blk_ready_o) begin
        obs_err++;
        return;
      end
      for (int s = 0; s < stall; s++) begin
        blk_valid_i = 1'b0;
        blk_data_i  = rand128();
        if (inj_mul && s == 0) begin
          inj_v = 1'b1;
          inj_r = {1'b0, rand128(), rand128()} >> 1;
        end
        @(negedge clk);
        inj_v = 1'b0;
        if (!blk_ready_o) obs_err++;
      end
      blk_valid_i = 1'b1;
      blk_data_i  = blk_arr[i];
      blk_last_i  = (i == n - 1);
      @(negedge clk);
      blk_valid_i = 1'b0;
      blk_last_i  = 1'b0;
      if (!mul_valid_o || blk_ready_o) obs_err++;
      obs_a_q.push_back(mul_a_o);
      obs_b_q.push_back(mul_b_o);
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (inj_start && k == 1) begin
          start_i = 1'b1;
          h_i     = ~h;
        end else begin
          start_i = 1'b0;
        end
        if (mul_valid_o) obs_err++;
        if (mul_a_o !== obs_a_q[$]) obs_err++;
      end while (!blk_ready_o && !tag_valid_o && k < 100);
      start_i = 1'b0;
      if (k != lat + 1) obs_err++;
      if (i == n - 1) begin
        if (!tag_valid_o) obs_err++;
        obs_tag = tag_o;
        @(negedge clk);
        if (tag_valid_o || busy_o) obs_err++;
        if (tag_o !== obs_tag) obs_err++;
      end else if (tag_valid_o) begin
        obs_err++;
      end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (mul_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_mul_valid got %0b want 0", mul_valid_o); end
    n_checks++; if (mul_a_o !== '0) begin n_fail++; $display("FAIL reset_mul_a got %h want 0", mul_a_o); end
    n_checks++; if (mul_b_o !== '0) begin n_fail++; $display("FAIL reset_mul_b got %h want 0", mul_b_o); end
    n_checks++; if (tag_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tag_valid got %0b want 0", tag_valid_o); end
    n_checks++; if (tag_o !== '0) begin n_fail++; $display("FAIL reset_tag got %h want 0", tag_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy_o); end
    n_checks++; if (blk_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", blk_ready_o); end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (mul_valid_o || busy_o || blk_ready_o) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL post_reset_quiet got %0d active cycles want 0", bad); end
  endtask

  task automatic test_identity();
    logic [W-1:0] x = 128'hDEADBEEF_00000000_12345678_CAFEF00D;
    lat = 4;
    blk_arr[0] = x;
    drive_msg(128'd1, 1, 1'b0, 1'b0, 0);
    n_checks++;
    if (obs_a_q.size() != 1) begin
      n_fail++; $display("FAIL identity_issues got %0d want 1", obs_a_q.size());
    end else begin
      if (obs_a_q[0] !== x) begin n_fail++; $display("FAIL identity_mul_a got %h want %h", obs_a_q[0], x); end
      n_checks++;
      if (obs_b_q[0] !== 128'd1) begin n_fail++; $display("FAIL identity_mul_b got %h want 1", obs_b_q[0]); end
    end
    n_checks++; if (obs_tag !== x) begin n_fail++; $display("FAIL identity_tag got %h want %h", obs_tag, x); end
    n_checks++; if (obs_err != 0) begin n_fail++; $display("FAIL identity_protocol got %0d errors want 0", obs_err); end
  endtask

  task automatic test_reduction_wrap();
    lat = 3;
    blk_arr[0] = 128'd1 << 127;
    drive_msg(128'd2, 1, 1'b0, 1'b0, 0);
    n_checks++; if (obs_tag !== 128'h87) begin n_fail++; $display("FAIL wrap_x_tag got %h want 87", obs_tag); end
    n_checks++; if (obs_err != 0) begin n_fail++; $display("FAIL wrap_x_protocol got %0d errors want 0", obs_err); end
    drive_msg(128'd4, 1, 1'b0, 1'b0, 0);
    n_checks++; if (obs_tag !== 128'h10E) begin n_fail++; $display("FAIL wrap_x2_tag got %h want 10e", obs_tag); end
    blk_arr[0] = {W{1'b1}};
    ghash_ref(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0001, 1);
    drive_msg(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0001, 1, 1'b0, 1'b0, 0);
    n_checks++; if (obs_tag !== exp_tag) begin n_fail++; $display("FAIL wrap_dense_tag got %h want %h", obs_tag, exp_tag); end
  endtask

  task automatic test_chaining();
    logic [W-1:0] want [3];
    want[0] = 128'h5; want[1] = 128'h6; want[2] = 128'h7;
    lat = 2;
    blk_arr[0] = 128'h5; blk_arr[1] = 128'h3; blk_arr[2] = 128'h1;
    drive_msg(128'd1, 3, 1'b0, 1'b0, 0);
    n_checks++;
    if (obs_a_q.size() != 3) begin
      n_fail++; $display("FAIL chain_issues got %0d want 3", obs_a_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (i > 0) n_checks++;
        if (obs_a_q[i] !== want[i]) begin n_fail++; $display("FAIL chain_mul_a[%0d] got %h want %h", i, obs_a_q[i], want[i]); end
      end
    end
    n_checks++; if (obs_tag !== 128'h7) begin n_fail++; $display("FAIL chain_tag got %h want 7", obs_tag); end
    n_checks++; if (obs_err != 0) begin n_fail++; $display("FAIL chain_protocol got %0d errors want 0", obs_err); end
  endtask

  task automatic test_random();
    logic [W-1:0] h;
    int n;
    for (int m = 0; m < 8; m++) begin
      lat = $urandom_range(1, 6);
      h   = rand128();
      n   = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) blk_arr[i] = rand128();
      ghash_ref(h, n);
      drive_msg(h, n, 1'b0, 1'b0, $urandom_range(0, 2));
      n_checks++;
      if (obs_a_q.size() != n) begin
        n_fail++; $display("FAIL rand%0d_issues got %0d want %0d", m, obs_a_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          n_checks++;
          if (obs_a_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_mul_a[%0d] got %h want %h", m, i, obs_a_q[i], exp_q[i]); end
          n_checks++;
          if (obs_b_q[i] !== h) begin n_fail++; $display("FAIL rand%0d_mul_b[%0d] got %h want %h", m, i, obs_b_q[i], h); end
        end
      end
      n_checks++; if (obs_tag !== exp_tag) begin n_fail++; $display("FAIL rand%0d_tag got %h want %h", m, obs_tag, exp_tag); end
      n_checks++; if (obs_err != 0) begin n_fail++; $display("FAIL rand%0d_protocol got %0d errors want 0 (lat %0d)", m, obs_err, lat); end
    end
  endtask

  task automatic test_robustness();
    logic [W-1:0] h = rand128();
    lat = 3;
    blk_arr[0] = rand128();
    blk_arr[1] = rand128();
    ghash_ref(h, 2);
    drive_msg(h, 2, 1'b1, 1'b1, 2);
    n_checks++; if (obs_tag !== exp_tag) begin n_fail++; $display("FAIL robust_tag got %h want %h", obs_tag, exp_tag); end
    n_checks++;
    if (obs_b_q.size() != 2) begin
      n_fail++; $display("FAIL robust_issues got %0d want 2", obs_b_q.size());
    end else if (obs_b_q[1] !== h) begin
      n_fail++; $display("FAIL robust_mul_b got %h want %h", obs_b_q[1], h);
    end
    n_checks++; if (obs_err != 0) begin n_fail++; $display("FAIL robust_protocol got %0d errors want 0", obs_err); end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] h = rand128();
    int k = 0;
    int bad = 0;
    lat = 5;
    @(negedge clk);
    start_i = 1'b1;
    h_i     = h;
    @(negedge clk);
    start_i = 1'b0;
    while (!blk_ready_o && k < 100) begin @(negedge clk); k++; end
    blk_valid_i = 1'b1;
    blk_data_i  = rand128();
    blk_last_i  = 1'b1;
    @(negedge clk);
    blk_valid_i = 1'b0;
    blk_last_i  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0 || blk_ready_o !== 1'b0) begin n_fail++; $display("FAIL midop_reset_idle got busy %0b ready %0b want 0 0", busy_o, blk_ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (tag_valid_o || busy_o || mul_valid_o) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midop_late_result got %0d active cycles want 0", bad); end
    n_checks++; if (tag_o !== '0) begin n_fail++; $display("FAIL midop_tag_cleared got %h want 0", tag_o); end
    lat = 2;
    h = rand128();
    blk_arr[0] = rand128();
    blk_arr[1] = rand128();
    ghash_ref(h, 2);
    drive_msg(h, 2, 1'b0, 1'b0, 0);
    n_checks++; if (obs_tag !== exp_tag) begin n_fail++; $display("FAIL midop_restart_tag got %h want %h", obs_tag, exp_tag); end
    n_checks++; if (obs_err != 0) begin n_fail++; $display("FAIL midop_restart_protocol got %0d errors want 0", obs_err); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_reduction_wrap();
    test_chaining();
    test_random();
    test_robustness();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
